wear_level_allocator: RTL and testbench

- Sequential free-block allocator for the flash controller.
- Owns the per-block erase counters and the free bitmap.
- Serves one allocation request at a time by scanning all blocks, one block per cycle, and grants the free block with the lowest erase count below THRESHOLD.
- Block release and erase completion reports arrive from the FTL/erase engine and update pool state in any cycle.

---
 rtl/wear_level_allocator.sv | 135 +++++++++++++
 tb/tb_wear_level_allocator.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/wear_level_allocator.sv
// Wear-levelling free-block allocator: owns the erase counters and the free bitmap,
// and grants the free block with the lowest erase count by a one-block-per-cycle scan.
module wear_level_allocator #(
  parameter int          BLOCKS    = 64,
  parameter int          ERASE_W   = 16,
  parameter int unsigned THRESHOLD = 1000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alloc_req,
  output logic                       alloc_ack,
  output logic                       alloc_fail,
  output logic [$clog2(BLOCKS)-1:0]  alloc_block,
  input  logic                       release_valid,
  input  logic [$clog2(BLOCKS)-1:0]  release_block,
  input  logic                       erase_done_valid,
  input  logic [$clog2(BLOCKS)-1:0]  erase_done_block,
  output logic                       busy,
  output logic [$clog2(BLOCKS):0]    free_count,
  input  logic [$clog2(BLOCKS)-1:0]  cnt_rd_addr,
  output logic [ERASE_W-1:0]         cnt_rd_data
);

  localparam int                 IW   = $clog2(BLOCKS);
  localparam int                 CW   = IW + 1;
  localparam logic [ERASE_W-1:0] THR  = ERASE_W'(THRESHOLD);
  localparam logic [IW-1:0]      LAST = IW'(BLOCKS - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t               state_q, state_d;
  logic [BLOCKS-1:0]    free_q, free_d;
  logic [ERASE_W-1:0]   cnt_q [BLOCKS];
  logic [CW-1:0]        free_count_q, free_count_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [IW-1:0]        best_idx_q, best_idx_d;
  logic [ERASE_W-1:0]   best_cnt_q, best_cnt_d;
  logic                 best_valid_q, best_valid_d;
  logic                 grant, eligible, last_idx, rel_new, er_new;

  function automatic logic [ERASE_W-1:0] sat_inc(input logic [ERASE_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    best_idx_d   = best_idx_q;
    best_cnt_d   = best_cnt_q;
    best_valid_d = best_valid_q;
    alloc_ack    = 1'b0;
    alloc_fail   = 1'b0;
    alloc_block  = '0;
    grant        = 1'b0;
    last_idx     = (idx_q == LAST);
    eligible     = free_q[idx_q] && (cnt_q[idx_q] < THR) && (cnt_q[idx_q] < best_cnt_q);
    case (state_q)
      IDLE: begin
        if (alloc_req) begin
          state_d      = SCAN;
          idx_d        = '0;
          best_idx_d   = '0;
          best_cnt_d   = '1;
          best_valid_d = 1'b0;
        end
      end
      SCAN: begin
        // strict less-than keeps the lowest index on ties
        if (eligible) begin
          best_cnt_d   = cnt_q[idx_q];
          best_idx_d   = idx_q;
          best_valid_d = 1'b1;
        end
        if (last_idx) state_d = DONE;
        else          idx_d   = idx_q + 1'b1;
      end
      DONE: begin
        if (best_valid_q) begin
          alloc_ack   = 1'b1;
          alloc_block = best_idx_q;
          grant       = 1'b1;
        end else begin
          alloc_fail  = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    free_d  = free_q;
    rel_new = release_valid && !free_q[release_block];
    // a same-block release already accounts for this 0->1 transition
    er_new  = erase_done_valid && !free_q[erase_done_block] &&
              !(release_valid && (release_block == erase_done_block));
    if (release_valid)    free_d[release_block]    = 1'b1;
    if (erase_done_valid) free_d[erase_done_block] = 1'b1;
    if (grant)            free_d[best_idx_q]       = 1'b0;
    free_count_d = free_count_q + CW'(rel_new) + CW'(er_new) - CW'(grant);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      best_idx_q   <= '0;
      best_cnt_q   <= '0;
      best_valid_q <= 1'b0;
      free_q       <= '1;
      free_count_q <= CW'(BLOCKS);
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      best_idx_q   <= best_idx_d;
      best_cnt_q   <= best_cnt_d;
      best_valid_q <= best_valid_d;
      free_q       <= free_d;
      free_count_q <= free_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BLOCKS; i++) cnt_q[i] <= '0;
    end else if (erase_done_valid) begin
      cnt_q[erase_done_block] <= sat_inc(cnt_q[erase_done_block]);
    end
  end

  assign busy        = (state_q != IDLE);
  assign free_count  = free_count_q;
  assign cnt_rd_data = cnt_q[cnt_rd_addr];

endmodule

// File: tb/tb_wear_level_allocator.sv
// Directed bench for wear_level_allocator: a 64-block instance and a small
// 8-block instance with THRESHOLD=3 for the threshold cases.
module tb_wear_level_allocator;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        a_req, a_ack, a_fail, a_rel_v, a_er_v, a_busy;
  logic [5:0]  a_blk, a_rel_b, a_er_b, a_rd;
  logic [6:0]  a_fc;
  logic [15:0] a_rd_data;

  logic        b_req, b_ack, b_fail, b_rel_v, b_er_v, b_busy;
  logic [2:0]  b_blk, b_rel_b, b_er_b, b_rd;
  logic [3:0]  b_fc;
  logic [15:0] b_rd_data;

  wear_level_allocator #(.BLOCKS(64), .ERASE_W(16), .THRESHOLD(1000)) dut_a (
    .clk(clk), .rst(rst), .alloc_req(a_req), .alloc_ack(a_ack), .alloc_fail(a_fail),
    .alloc_block(a_blk), .release_valid(a_rel_v), .release_block(a_rel_b),
    .erase_done_valid(a_er_v), .erase_done_block(a_er_b), .busy(a_busy),
    .free_count(a_fc), .cnt_rd_addr(a_rd), .cnt_rd_data(a_rd_data));

  wear_level_allocator #(.BLOCKS(8), .ERASE_W(16), .THRESHOLD(3)) dut_b (
    .clk(clk), .rst(rst), .alloc_req(b_req), .alloc_ack(b_ack), .alloc_fail(b_fail),
    .alloc_block(b_blk), .release_valid(b_rel_v), .release_block(b_rel_b),
    .erase_done_valid(b_er_v), .erase_done_block(b_er_b), .busy(b_busy),
    .free_count(b_fc), .cnt_rd_addr(b_rd), .cnt_rd_data(b_rd_data));

  int   n_cmp = 0;
  int   n_bad = 0;
  logic sel;

  typedef struct {
    int   op;       // 0: one-cycle release/erase pulse, 1: allocation
    int   rel_b;    // -1 = none
    int   er_b;     // -1 = none
    int   ev_at;    // scan cycle of the event during an allocation (0 = none)
    logic exp_ack;
    int   exp_blk;
    int   exp_fc;
  } step_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic o_ack();  return sel ? b_ack  : a_ack;  endfunction
  function automatic logic o_fail(); return sel ? b_fail : a_fail; endfunction
  function automatic logic o_busy(); return sel ? b_busy : a_busy; endfunction
  function automatic logic [31:0] o_blk(); return sel ? 32'(b_blk) : 32'(a_blk); endfunction
  function automatic logic [31:0] o_fc();  return sel ? 32'(b_fc)  : 32'(a_fc);  endfunction

  task automatic drive(input logic req, input logic rv, input int rb, input logic ev, input int eb);
    if (sel) begin
      b_req = req; b_rel_v = rv; b_rel_b = 3'(rb); b_er_v = ev; b_er_b = 3'(eb);
    end else begin
      a_req = req; a_rel_v = rv; a_rel_b = 6'(rb); a_er_v = ev; a_er_b = 6'(eb);
    end
  endtask

  task automatic pulse(input int rb, input int eb);
    drive(1'b0, rb >= 0, (rb >= 0) ? rb : 0, eb >= 0, (eb >= 0) ? eb : 0);
    @(negedge clk);
    drive(1'b0, 1'b0, 0, 1'b0, 0);
  endtask

  task automatic rd_chk(input string name, input int addr, input int exp);
    if (sel) b_rd = 3'(addr); else a_rd = 6'(addr);
    #1;
    chk(name, sel ? 32'(b_rd_data) : 32'(a_rd_data), 32'(exp));
  endtask

  task automatic alloc(input int ev_at, input int rel_b, input int er_b,
                       output logic got_ack, output logic got_fail,
                       output int got_blk, output int nbusy);
    logic req;
    logic done;
    int   eb;
    req = 1'b1; done = 1'b0;
    got_ack = 1'b0; got_fail = 1'b0; got_blk = 0; nbusy = 0;
    eb = (rel_b >= 0) ? rel_b : ((er_b >= 0) ? er_b : 0);
    drive(1'b1, 1'b0, 0, 1'b0, 0);
    for (int k = 1; k <= 200 && !done; k++) begin
      @(negedge clk);
      if (o_busy()) nbusy++;
      if (o_ack() || o_fail()) begin
        got_ack = o_ack(); got_fail = o_fail(); got_blk = int'(o_blk());
        req = 1'b0; done = 1'b1;
      end
      if (k == ev_at) drive(req, rel_b >= 0, eb, er_b >= 0, eb);
      else            drive(req, 1'b0, 0, 1'b0, 0);
    end
    chk("alloc_completes", 32'(done), 32'd1);
    @(negedge clk);
    drive(1'b0, 1'b0, 0, 1'b0, 0);
    chk("busy_after_alloc", 32'(o_busy()), 32'd0);
  endtask

  task automatic run_alloc(input string tag, input int ev_at, input int rel_b, input int er_b,
                           input logic exp_ack, input int exp_blk, input int exp_fc);
    logic ga, gf;
    int   gb, nb;
    alloc(ev_at, rel_b, er_b, ga, gf, gb, nb);
    chk({tag, "_ack"},  32'(ga), 32'(exp_ack));
    chk({tag, "_fail"}, 32'(gf), 32'(!exp_ack));
    chk({tag, "_blk"},  32'(gb), 32'(exp_blk));
    chk({tag, "_fc"},   o_fc(),  32'(exp_fc));
  endtask

  initial begin
    step_t steps[16];
    logic  ga, gf;
    int    gb, nb, seen;

    steps[0]  = '{0, 10, 10,  0, 1'b0,  0, 1};
    steps[1]  = '{0, 11, 12,  0, 1'b0,  0, 3};
    steps[2]  = '{1, -1, -1,  0, 1'b1, 11, 2};
    steps[3]  = '{1, -1, -1,  0, 1'b1, 10, 1};
    steps[4]  = '{1, -1, -1,  0, 1'b1, 12, 0};
    steps[5]  = '{1, -1, -1,  0, 1'b0,  0, 0};
    steps[6]  = '{0, 40, -1,  0, 1'b0,  0, 1};
    steps[7]  = '{1,  9, -1, 21, 1'b1, 40, 1};
    steps[8]  = '{1, -1, -1,  0, 1'b1,  9, 0};
    steps[9]  = '{0,  0, -1,  0, 1'b0,  0, 1};
    steps[10] = '{1, 30, -1,  6, 1'b1, 30, 1};
    steps[11] = '{1, -1,  0, 65, 1'b1,  0, 0};
    steps[12] = '{0,  0, -1,  0, 1'b0,  0, 1};
    steps[13] = '{1,  0, -1, 65, 1'b1,  0, 0};
    steps[14] = '{0, -1,  0,  0, 1'b0,  0, 1};
    steps[15] = '{0, -1,  0,  0, 1'b0,  0, 1};

    rst = 1'b1;
    a_req = 0; a_rel_v = 0; a_rel_b = 0; a_er_v = 0; a_er_b = 0; a_rd = 0;
    b_req = 0; b_rel_v = 0; b_rel_b = 0; b_er_v = 0; b_er_b = 0; b_rd = 0;
    sel = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    chk("rst_fc_a",   32'(a_fc),   32'd64);
    chk("rst_fc_b",   32'(b_fc),   32'd8);
    chk("rst_busy",   32'(a_busy), 32'd0);
    chk("rst_ack",    32'(a_ack),  32'd0);
    chk("rst_fail",   32'(a_fail), 32'd0);
    chk("rst_blk",    32'(a_blk),  32'd0);
    rd_chk("rst_cnt0", 0, 0);

    // small instance: threshold boundary
    sel = 1'b1;
    for (int i = 0; i < 8; i++) run_alloc($sformatf("b_fill%0d", i), 0, -1, -1, 1'b1, i, 7 - i);
    pulse(-1, 5); pulse(-1, 5); pulse(-1, 5);
    chk("b_fc_after_erase5", o_fc(), 32'd1);
    rd_chk("b_cnt5", 5, 3);
    run_alloc("b_thr_fail", 0, -1, -1, 1'b0, 0, 1);
    pulse(-1, 6); pulse(-1, 6);
    chk("b_fc_after_erase6", o_fc(), 32'd2);
    run_alloc("b_below_thr", 0, -1, -1, 1'b1, 6, 1);

    // main instance: first allocation latency
    sel = 1'b0;
    alloc(0, -1, -1, ga, gf, gb, nb);
    chk("first_ack",  32'(ga), 32'd1);
    chk("first_blk",  32'(gb), 32'd0);
    chk("first_busy", 32'(nb), 32'd65);
    chk("first_fc",   o_fc(),  32'd63);

    pulse(-1, 0); pulse(-1, 0); pulse(-1, 1); pulse(-1, 1);
    pulse(-1, 2); pulse(-1, 2); pulse(-1, 3);
    chk("fc_after_erases", o_fc(), 32'd64);
    rd_chk("cnt0_is2", 0, 2);
    rd_chk("cnt3_is1", 3, 1);
    run_alloc("low_count", 0, -1, -1, 1'b1, 4, 63);

    for (int i = 0; i < 63; i++)
      run_alloc($sformatf("drain%0d", i), 0, -1, -1, 1'b1,
                (i < 59) ? i + 5 : ((i == 59) ? 3 : i - 60), 62 - i);
    run_alloc("empty_fail", 0, -1, -1, 1'b0, 0, 0);
    pulse(7, -1);
    chk("fc_after_rel7", o_fc(), 32'd1);
    run_alloc("regrant7", 0, -1, -1, 1'b1, 7, 0);

    for (int i = 0; i < 16; i++) begin
      if (steps[i].op == 0) begin
        pulse(steps[i].rel_b, steps[i].er_b);
        chk($sformatf("step%0d_fc", i), o_fc(), 32'(steps[i].exp_fc));
      end else begin
        run_alloc($sformatf("step%0d", i), steps[i].ev_at, steps[i].rel_b, steps[i].er_b,
                  steps[i].exp_ack, steps[i].exp_blk, steps[i].exp_fc);
      end
    end
    rd_chk("cnt0_is5",  0, 5);
    rd_chk("cnt10_is1", 10, 1);
    rd_chk("cnt12_is1", 12, 1);
    rd_chk("cnt11_is0", 11, 0);

    // reset in the middle of a scan
    drive(1'b1, 1'b0, 0, 1'b0, 0);
    repeat (31) @(negedge clk);
    chk("busy_mid_scan", 32'(a_busy), 32'd1);
    rst = 1'b1;
    drive(1'b0, 1'b0, 0, 1'b0, 0);
    @(negedge clk);
    chk("rst_scan_busy", 32'(a_busy), 32'd0);
    chk("rst_scan_fc",   32'(a_fc),   32'd64);
    chk("rst_scan_ack",  32'(a_ack | a_fail), 32'd0);
    rd_chk("rst_scan_cnt0", 0, 0);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 70; k++) begin
      @(negedge clk);
      if (a_ack || a_fail || a_busy) seen++;
    end
    chk("no_pulse_after_rst", 32'(seen), 32'd0);

    // erase counter saturation
    a_rd = 6'd1;
    drive(1'b0, 1'b0, 0, 1'b1, 1);
    repeat (65534) @(negedge clk);
    chk("cnt1_fffe", 32'(a_rd_data), 32'hFFFE);
    @(negedge clk);
    chk("cnt1_ffff", 32'(a_rd_data), 32'hFFFF);
    @(negedge clk);
    drive(1'b0, 1'b0, 0, 1'b0, 0);
    chk("cnt1_sat", 32'(a_rd_data), 32'hFFFF);
    chk("sat_fc",   32'(a_fc),      32'd64);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
